// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end constants: data width, NOP encoding, major opcodes
// and the fetch sequencer state type.
package riscv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic {
        BOOT,
        RUN
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with a flush that dominates same-cycle push/pop.
// The head entry is read directly from the storage registers.
module fetch_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_data,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_do_push = i_push && !i_flush && !w_full;
    assign w_do_pop  = i_pop && !i_flush && (r_count != '0);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // NOTE: storage is not reset; the count qualifies every read, so no reset tree is spent on data.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head_data = r_mem[r_rd_ptr];
    assign o_empty     = (r_count == '0);
    assign o_count     = r_count;

    // Upstream credit accounting must never offer a push into a full buffer.
    assert property (@(posedge clk) disable iff (!rst_n) !(i_push && !i_flush && w_full));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credited word requests to
// instruction memory, buffers responses and applies controller redirects.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN       = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            stall,
    input  logic            pc_sel,
    input  logic [XLEN-1:0] pc_target,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic            funct7b5,
    output logic            misalign_err
);

    localparam int           CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int           EW      = 2 * XLEN;
    localparam logic [CW:0]  CREDITS = (CW + 1)'(FIFO_DEPTH);

    fetch_state_e    r_state;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_push_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_discard_cnt;
    logic            r_misalign_err;

    logic [CW-1:0]   w_fifo_count;
    logic            w_fifo_empty;
    logic [EW-1:0]   w_head;
    logic [CW:0]     w_credit_used;
    logic [CW-1:0]   w_outstanding_next;
    logic [XLEN-1:0] w_target;
    logic            w_req_fire;
    logic            w_redirect;
    logic            w_discard;
    logic            w_push;
    logic            w_pop;

    // Issue depends only on registered state; a same-cycle pop frees no credit.
    assign w_credit_used  = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
    assign imem_req_valid = (r_state == RUN) && (w_credit_used < CREDITS);
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign instr_valid = !w_fifo_empty;
    assign w_pop       = instr_valid && !stall;
    assign w_redirect  = pc_sel && instr_valid && !stall;
    assign w_target    = {pc_target[XLEN-1:2], 2'b00};

    // Everything accepted but not yet answered after this edge becomes stale on a redirect.
    assign w_outstanding_next = r_outstanding + CW'(w_req_fire) - CW'(imem_rsp_valid);
    assign w_discard          = imem_rsp_valid && ((r_discard_cnt != '0) || w_redirect);
    assign w_push             = imem_rsp_valid && !w_discard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= BOOT;
            r_fetch_pc     <= RESET_PC;
            r_push_pc      <= RESET_PC;
            r_outstanding  <= '0;
            r_discard_cnt  <= '0;
            r_misalign_err <= 1'b0;
        end else begin
            r_state       <= RUN;
            r_outstanding <= w_outstanding_next;
            if (w_redirect) begin
                r_fetch_pc    <= w_target;
                r_push_pc     <= w_target;
                r_discard_cnt <= w_outstanding_next;
                if (pc_target[1:0] != 2'b00) r_misalign_err <= 1'b1;
            end else begin
                if (w_req_fire) r_fetch_pc <= r_fetch_pc + XLEN'(4);
                if (w_push)     r_push_pc  <= r_push_pc + XLEN'(4);
                if (imem_rsp_valid && (r_discard_cnt != '0))
                    r_discard_cnt <= r_discard_cnt - CW'(1);
            end
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (w_redirect),
        .i_push      (w_push),
        .i_push_data ({r_push_pc, imem_rsp_data}),
        .i_pop       (w_pop),
        .o_head_data (w_head),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    assign instr        = instr_valid ? w_head[XLEN-1:0] : XLEN'(NOP_INSTR);
    assign instr_pc     = instr_valid ? w_head[EW-1:XLEN] : '0;
    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign funct7b5     = instr[30];
    assign misalign_err = r_misalign_err;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a latency-programmable memory model answers
// requests, and every delivered instruction is checked against the expected stream.
module tb_fetch_unit;
    import riscv_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        stall;
    logic        pc_sel;
    logic [31:0] pc_target;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        misalign_err;

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN       (32),
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .stall          (stall),
        .pc_sel         (pc_sel),
        .pc_target      (pc_target),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .opcode         (opcode),
        .funct3         (funct3),
        .funct7b5       (funct7b5),
        .misalign_err   (misalign_err)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    exp_t        exp_q[$];
    rsp_t        rsp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          lat = 1;
    int          n_pops = 0;
    logic        mem_ready = 1'b1;
    logic [31:0] exp_pc = RST_PC;
    logic        first_pc_chk = 1'b0;
    logic [31:0] first_pc_exp = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ {a[7:0], 24'h0};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        check({tag, "_req_addr"}, imem_req_addr, RST_PC);
        check({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
        check({tag, "_instr"}, instr, NOP_INSTR);
        check({tag, "_instr_pc"}, instr_pc, 32'd0);
        check({tag, "_misalign"}, 32'(misalign_err), 32'd0);
    endtask

    // One clock: drive memory response, evaluate the cycle's events at mid-cycle, advance.
    task automatic step();
        exp_t e;
        rsp_t r;
        logic redirect;
        @(negedge clk);
        cyc++;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = rsp_q[0].data;
            void'(rsp_q.pop_front());
        end
        imem_req_ready = mem_ready;
        #1;
        redirect = pc_sel && instr_valid && !stall;
        if (instr_valid) begin
            check("sb_avail", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q[0];
                check("instr_pc", instr_pc, e.pc);
                check("instr", instr, e.data);
                check("opcode", 32'(opcode), 32'(e.data[6:0]));
                check("funct3", 32'(funct3), 32'(e.data[14:12]));
                check("funct7b5", 32'(funct7b5), 32'(e.data[30]));
                if (!stall) begin
                    void'(exp_q.pop_front());
                    n_pops++;
                    if (first_pc_chk) begin
                        check("redir_first_pc", instr_pc, first_pc_exp);
                        first_pc_chk = 1'b0;
                    end
                end
            end
        end else begin
            check("empty_nop", instr, NOP_INSTR);
        end
        if (imem_req_valid && imem_req_ready) begin
            check("req_addr", imem_req_addr, exp_pc);
            e.pc   = exp_pc;
            e.data = mem_word(exp_pc);
            exp_q.push_back(e);
            r.due  = cyc + lat;
            r.data = mem_word(imem_req_addr);
            rsp_q.push_back(r);
            exp_pc = exp_pc + 32'd4;
        end
        if (redirect) begin
            exp_q.delete();
            exp_pc = {pc_target[31:2], 2'b00};
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] target, input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            if (instr_valid) begin
                pc_sel    = 1'b1;
                pc_target = target;
                step();
                pc_sel       = 1'b0;
                first_pc_chk = 1'b1;
                first_pc_exp = {target[31:2], 2'b00};
                done         = 1'b1;
            end else begin
                step();
            end
        end
        check(tag, 32'(done), 32'd1);
    endtask

    initial begin
        logic found;
        stall          = 1'b0;
        pc_sel         = 1'b0;
        pc_target      = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;

        #2 rst_n = 1'b0;
        #1 check_reset("rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Boot cycle, first request, first delivery latency, then sustained rate.
        check("boot_no_req", 32'(imem_req_valid), 32'd0);
        step();
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_req_addr", imem_req_addr, RST_PC);
        step();
        check("no_early_valid", 32'(instr_valid), 32'd0);
        step();
        check("first_valid_lat", 32'(instr_valid), 32'd1);
        n_pops = 0;
        repeat (16) step();
        check("throughput", 32'(n_pops), 32'd16);

        // Downstream stall: credits run out, head holds.
        stall = 1'b1;
        repeat (10) step();
        check("stall_credit_stop", 32'(imem_req_valid), 32'd0);
        check("stall_buf_valid", 32'(instr_valid), 32'd1);
        stall = 1'b0;
        repeat (12) step();

        // Memory not ready: request held stable.
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("rdy_low_valid", 32'(imem_req_valid), 32'd1);
            check("rdy_low_addr", imem_req_addr, exp_pc);
        end
        mem_ready = 1'b1;
        repeat (8) step();

        // Redirect with three requests in flight at latency 3.
        lat = 3;
        repeat (10) step();
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (rsp_q.size() == 3 && instr_valid) begin
                pc_sel    = 1'b1;
                pc_target = 32'h0000_0100;
                step();
                pc_sel       = 1'b0;
                first_pc_chk = 1'b1;
                first_pc_exp = 32'h0000_0100;
                found        = 1'b1;
            end else begin
                step();
            end
        end
        check("redir3_found", 32'(found), 32'd1);
        repeat (15) step();
        check("redir3_delivered", 32'(first_pc_chk), 32'd0);
        check("aligned_no_misalign", 32'(misalign_err), 32'd0);

        // Redirect in the same cycle as a response and a request handshake.
        lat = 1;
        repeat (6) step();
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (rsp_q.size() != 0 && rsp_q[0].due <= cyc + 1 && imem_req_valid && mem_ready && instr_valid) begin
                pc_sel    = 1'b1;
                pc_target = 32'h0000_0200;
                step();
                pc_sel       = 1'b0;
                first_pc_chk = 1'b1;
                first_pc_exp = 32'h0000_0200;
                found        = 1'b1;
            end else begin
                step();
            end
        end
        check("coinc_found", 32'(found), 32'd1);
        repeat (10) step();
        check("coinc_delivered", 32'(first_pc_chk), 32'd0);

        // Misaligned target: sticky flag, fetch resumes at the aligned address.
        do_redirect(32'h0000_0102, "misalign_redir");
        check("misalign_set", 32'(misalign_err), 32'd1);
        repeat (8) step();
        check("misalign_delivered", 32'(first_pc_chk), 32'd0);
        check("misalign_sticky", 32'(misalign_err), 32'd1);

        // Asynchronous reset in the middle of a burst.
        #2 rst_n = 1'b0;
        #1 check_reset("midrst");
        exp_q.delete();
        rsp_q.delete();
        exp_pc         = RST_PC;
        first_pc_chk   = 1'b0;
        imem_rsp_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("boot2_no_req", 32'(imem_req_valid), 32'd0);
        first_pc_chk = 1'b1;
        first_pc_exp = RST_PC;
        repeat (20) step();
        check("restart_delivered", 32'(first_pc_chk), 32'd0);

        // Drain everything and confirm credits are fully returned.
        mem_ready = 1'b0;
        found     = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (exp_q.size() == 0 && rsp_q.size() == 0) found = 1'b1;
            else step();
        end
        check("drain_done", 32'(found), 32'd1);
        repeat (2) step();
        check("credit_restored", 32'(imem_req_valid), 32'd1);
        check("drained_empty", 32'(instr_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the controller/decode logic. It owns the PC, issues word requests to instruction memory over a valid/ready request channel with in-order responses, and buffers returned instructions in a small FIFO. It presents the head instruction with its PC and pre-sliced opcode/funct3/funct7b5 fields. It applies taken-branch/jump redirects from PC_sel and PC target, flushing the buffer and squashing stale in-flight responses.

Parameters:
XLEN, 32, address/instruction width
RESET_PC, 32'h0000_0000, first fetch address after reset
FIFO_DEPTH, 4, instruction buffer entries; also the max outstanding-plus-buffered credit (power of two, ≥2)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
imem_req_valid  out  1  request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  word-aligned fetch address
imem_rsp_valid  in  1  response valid (in order, ≥1 cycle after acceptance, never back-pressured)
imem_rsp_data  in  XLEN  fetched instruction
stall  in  1  downstream not consuming this cycle
pc_sel  in  1  redirect request from controller
pc_target  in  XLEN  redirect address
instr_valid  out  1  FIFO non-empty
instr  out  XLEN  head instruction; 32'h0000_0013 (NOP) when empty
instr_pc  out  XLEN  PC of head instruction
opcode  out  7  instr[6:0]
funct3  out  3  instr[14:12]
funct7b5  out  1  instr[30]
misalign_err  out  1  sticky: redirect target with [1:0]≠0

Behaviour:
- Reset (async assert): fetch_pc=RESET_PC, FIFO empty, outstanding=0, discard_cnt=0, state=BOOT, misalign_err=0; outputs: imem_req_valid=0, imem_req_addr=RESET_PC, instr_valid=0, instr=NOP, instr_pc=0.
- FSM: BOOT → RUN unconditionally on the first clock after reset deassertion (no request in BOOT). RUN persists until reset.
- Issue: in RUN, imem_req_valid=1 iff outstanding+fifo_count < FIFO_DEPTH (same-cycle pop not credited). imem_req_valid must not depend combinationally on pc_sel, stall or imem_rsp_*. On handshake: outstanding++, fetch_pc+=4 (wraps modulo 2^XLEN). addr/valid hold stable while valid && !ready.
- Response: outstanding-- on imem_rsp_valid. If discard_cnt>0: drop data, discard_cnt--. Otherwise push {data, pc} into FIFO; PC tracked by a push-side PC register advancing +4 per push.
- Consume: pop when instr_valid && !stall. Head fields are registered in the FIFO; push-to-instr_valid latency = 1 cycle.
- Redirect: effective only when pc_sel && instr_valid && !stall (otherwise ignored). In that cycle: FIFO flushed (any same-cycle push dropped); fetch_pc and push-side PC ← {pc_target[XLEN-1:2],2'b00}; discard_cnt ← outstanding_next, i.e. all requests accepted up to and including this cycle that have not responded. misalign_err set if pc_target[1:0]≠0.
- Redirect coinciding with a response: the response is discarded and not counted in discard_cnt.
- Redirect while discard_cnt>0: discard_cnt recomputed as above; the count never double-counts.
- Full FIFO: the credit rule guarantees no push when full; an overflow is an assertion failure.
- Throughput: 1 instr/cycle sustained when memory latency ≤ FIFO_DEPTH−2.

Decomposition:
- riscv_pkg: XLEN, NOP_INSTR=32'h0000_0013, opcode localparams (OP_LUI, OP_JAL, OP_BRANCH, ...), fetch_state_e {BOOT, RUN}.
- Sub-module fetch_fifo: synchronous FIFO with flush, parameterised width/depth, count output; stores {pc, instr}.

Test Plan:
- Reset release, ready=1, 1-cycle memory, stall=0 → first request at 0x0 one cycle after BOOT; instr_valid two cycles after that; instr_pc 0x0,0x4,0x8... at 1/cycle.
- stall=1 for 10 cycles → requests stop after 4 credits; instr/instr_pc hold; release → sequence resumes with no loss or duplication.
- imem_req_ready=0 for 5 cycles → imem_req_addr and valid held constant; no outstanding increment.
- Redirect to 0x100 with 3 requests outstanding (latency 3) → the 3 stale responses dropped; next instr_valid carries instr_pc=0x100.
- Redirect coinciding with imem_rsp_valid and a request handshake → both stale words discarded; first delivered PC = target; outstanding returns to 0.
- pc_target=0x102 → misalign_err=1 (sticky); fetch resumes at 0x100; rst_n asserted mid-burst → all outputs reach reset values immediately and fetch restarts at RESET_PC.
